// File: rtl/ibex_pext_simd_mac.sv
`default_nettype none
// ============================================================================
// Module      : ibex_pext_simd_mac
// Description : Multi-cycle SIMD multiply-accumulate for the P-extension.
//               Each lane computes rs3 + rs1*rs2 on 8- or 16-bit elements.
//               Lanes are processed NumMul at a time, so a full operation
//               takes N = (Width/E)/NumMul cycles. Overflow handling per op
//               is wrap, saturate or high-half. A sticky OV flag (RDOV) is
//               also kept, and it is cleared by CLROV.
// Parameters  : Width  - operand/result width (power of two, >= 32)
//               NumMul - lanes per cycle (divides Width/16)
// Ports       : clk_i, rst_ni           clock, async active-low reset
//               valid_i / ready_o       request handshake (ready only in IDLE)
//               rs1_i, rs2_i, rs3_i     multiplicand, multiplier, accumuland
//               signed_type_i           U16=0, U8=1, S16=2, S8=3
//               overflow_i              NONE=0, HALVING=1, SATURATING=2 (3=NONE)
//               valid_o / ready_i       result handshake
//               result_o, ov_o          packed lane results, per-op clip flag
//               ov_sticky_o, clr_ov_i   sticky OV flag and its clear
// Config      : define IBEX_PEXT_MAC_ROUND_EN to round HALVING results
//               (adds 2^(E-1) before taking the high half); default truncates.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_pext_simd_mac #(
  parameter int Width  = 32,
  parameter int NumMul = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] rs1_i,
  input  logic [Width-1:0] rs2_i,
  input  logic [Width-1:0] rs3_i,
  input  logic [1:0]       signed_type_i,
  input  logic [1:0]       overflow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] result_o,
  output logic             ov_o,
  output logic             ov_sticky_o,
  input  logic             clr_ov_i
);

  localparam int L16  = Width / 16;
  localparam int L8   = Width / 8;
  localparam int N16  = L16 / NumMul;
  localparam int N8   = L8 / NumMul;
  localparam int CNTW = $clog2(N8) + 1;
  localparam int IDXW = $clog2(L8) + 1;
  localparam int SHW  = IDXW + 4;

`ifdef IBEX_PEXT_MAC_ROUND_EN
  localparam logic C_ROUND_EN = 1'b1;
`else
  localparam logic C_ROUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNTW-1:0]   r_cnt;
  logic [Width-1:0]  r_rs1;
  logic [Width-1:0]  r_rs2;
  logic [Width-1:0]  r_rs3;
  logic [1:0]        r_type;
  logic [1:0]        r_ovf;
  logic [Width-1:0]  r_res;
  logic              r_ov_op;
  logic              r_ov_sticky;

  logic              w_e8;
  logic              w_sgn;
  logic              w_half;
  logic              w_sat;
  logic              w_last;
  logic              w_clip_any;
  logic              w_set_sticky;

  logic [IDXW-1:0]   w_lane_idx  [NumMul];
  logic [15:0]       w_lane_res  [NumMul];
  logic [NumMul-1:0] w_lane_clip;

  assign w_e8   = r_type[0];
  assign w_sgn  = r_type[1];
  assign w_half = (r_ovf == 2'd1);
  assign w_sat  = (r_ovf == 2'd2);
  assign w_last = (r_cnt == (w_e8 ? CNTW'(N8 - 1) : CNTW'(N16 - 1)));

  // --------------------------------------------------------------------------
  // Lane datapath: NumMul independent lanes, each handling one element of
  // either width. Elements are picked out of the latched operands by shifting.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NumMul; k++) begin : g_lane
    logic [SHW-1:0]     w_shamt;
    logic [15:0]        w_a, w_b, w_c;
    logic [16:0]        w_a17, w_b17, w_c17;
    logic [33:0]        w_prod, w_sum, w_hs;
    logic signed [33:0] w_hi, w_lo;
    logic [15:0]        w_res;
    logic               w_clip;

    assign w_lane_idx[k] = IDXW'(r_cnt) * IDXW'(NumMul) + IDXW'(k);

    always_comb begin
      w_shamt = w_e8 ? {1'b0, w_lane_idx[k], 3'b000} : {w_lane_idx[k], 4'b0000};
      w_a = 16'(r_rs1 >> w_shamt);
      w_b = 16'(r_rs2 >> w_shamt);
      w_c = 16'(r_rs3 >> w_shamt);

      if (w_e8) begin
        w_a17 = {{9{w_sgn & w_a[7]}}, w_a[7:0]};
        w_b17 = {{9{w_sgn & w_b[7]}}, w_b[7:0]};
        w_c17 = {{9{w_sgn & w_c[7]}}, w_c[7:0]};
      end else begin
        w_a17 = {w_sgn & w_a[15], w_a};
        w_b17 = {w_sgn & w_b[15], w_b};
        w_c17 = {w_sgn & w_c[15], w_c};
      end

      // Sign-extend to 34 bits first so the modular product is exact for
      // both signed and unsigned lanes.
      w_prod = {{17{w_a17[16]}}, w_a17} * {{17{w_b17[16]}}, w_b17};
      w_sum  = w_prod + {{17{w_c17[16]}}, w_c17};
      w_hs   = w_sum + ((w_half && C_ROUND_EN) ? (w_e8 ? 34'h80 : 34'h8000) : 34'h0);

      if (w_sgn) begin
        w_hi = w_e8 ? 34'sd127 : 34'sd32767;
        w_lo = w_e8 ? -34'sd128 : -34'sd32768;
      end else begin
        w_hi = w_e8 ? 34'sd255 : 34'sd65535;
        w_lo = 34'sd0;
      end

      w_res  = w_e8 ? {8'h00, 8'(w_sum)} : 16'(w_sum);
      w_clip = 1'b0;
      if (w_half) begin
        w_res = w_e8 ? {8'h00, 8'(w_hs >> 8)} : 16'(w_hs >> 16);
      end else if (w_sat) begin
        if ($signed(w_sum) > w_hi) begin
          w_res  = 16'(w_hi);
          w_clip = 1'b1;
        end else if ($signed(w_sum) < w_lo) begin
          w_res  = 16'(w_lo);
          w_clip = 1'b1;
        end
      end
    end

    assign w_lane_res[k]  = w_res;
    assign w_lane_clip[k] = w_clip;
  end

  assign w_clip_any = |w_lane_clip;

  // Sticky set uses the flag as it will be after this last CALC edge, so a
  // clip in the final lane group still counts.
  assign w_set_sticky = (r_state == S_CALC) && w_last && (r_ov_op || w_clip_any);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (valid_i) w_state_nxt = S_CALC;
      S_CALC:  if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  if (ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand latch, lane counter and result accumulation
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rs3   <= '0;
      r_type  <= '0;
      r_ovf   <= '0;
      r_res   <= '0;
      r_ov_op <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_rs1   <= rs1_i;
            r_rs2   <= rs2_i;
            r_rs3   <= rs3_i;
            r_type  <= signed_type_i;
            r_ovf   <= overflow_i;
            r_cnt   <= '0;
            r_ov_op <= 1'b0;
          end
        end
        S_CALC: begin
          for (int k = 0; k < NumMul; k++) begin
            if (w_e8) begin
              r_res[{w_lane_idx[k], 3'b000} +: 8] <= w_lane_res[k][7:0];
            end else begin
              r_res[{w_lane_idx[k], 4'b0000} +: 16] <= w_lane_res[k];
            end
          end
          r_ov_op <= r_ov_op | w_clip_any;
          r_cnt   <= w_last ? '0 : r_cnt + CNTW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Set has priority over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ov_sticky <= 1'b0;
    end else if (w_set_sticky) begin
      r_ov_sticky <= 1'b1;
    end else if (clr_ov_i) begin
      r_ov_sticky <= 1'b0;
    end
  end

  assign ready_o     = (r_state == S_IDLE);
  assign valid_o     = (r_state == S_DONE);
  assign result_o    = r_res;
  assign ov_o        = r_ov_op;
  assign ov_sticky_o = r_ov_sticky;

endmodule
`default_nettype wire

// File: doc/ibex_pext_simd_mac.md
# ibex_pext_simd_mac

Multi-cycle SIMD multiply-accumulate unit for the P-extension datapath, generalising the fixed 32-bit lane arithmetic to a parametrised operand width and a parametrised number of physical multipliers, traded against latency. It sits beside the ALU in the EX stage, takes three register operands through a valid/ready handshake, and computes per-lane `rs3 + rs1*rs2` for 8- or 16-bit lanes. Per-instruction overflow handling is wrap, saturate or high-half. It also maintains the sticky OV flag read by RDOV and cleared by CLROV.

## Interface
Parameters:
- `Width`, 32: operand/result width; a power of two, at least 32.
- `NumMul`, 1: lanes processed per cycle; must divide `Width/16`.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `valid_i`  in  1  operation request.
- `ready_o`  out  1  unit can accept (high only in IDLE).
- `rs1_i`, `rs2_i`, `rs3_i`  in  Width  multiplicand, multiplier, accumuland.
- `signed_type_i`  in  2  lane type: U16=0, U8=1, S16=2, S8=3.
- `overflow_i`  in  2  NONE=0 (wrap), HALVING=1 (high half), SATURATING=2; value 3 is treated as NONE.
- `valid_o`  out  1  result available.
- `ready_i`  in  1  consumer takes result.
- `result_o`  out  Width  packed lane results.
- `ov_o`  out  1  at least one lane saturated in this result.
- `ov_sticky_o`  out  1  sticky OV flag.
- `clr_ov_i`  in  1  clear sticky OV (CLROV).

## Operation
- The element width E is 16 or 8. The lane count is L = Width/E and the iteration count is N = L/NumMul.
- Each lane forms a full-precision sum `s = rs3[lane] + rs1[lane]*rs2[lane]` (2E+1 bits), using sign or zero extension per `signed_type_i`.
- NONE: the lane result is `s[E-1:0]`.
- SATURATING: `s` is clipped to the E-bit signed or unsigned range. Any clip sets the per-op overflow flag.
- HALVING: the lane result is `s[2E-1:E]`. No saturation and no flag.
- FSM has three states:
  - IDLE: `ready_o`=1. On `valid_i`, latch all inputs, clear the lane counter and the per-op flag, and go to CALC.
  - CALC: each cycle compute lanes `cnt*NumMul .. cnt*NumMul+NumMul-1` into the result register and OR their clip flags into the per-op flag. After N cycles go to DONE.
  - DONE: `valid_o`=1, with `result_o` and `ov_o` stable. On `ready_i`, go to IDLE.
- Sticky OV is set on entry to DONE if the per-op flag is 1. `clr_ov_i` clears it in any state. If a set and a clear occur in the same cycle, the set wins.
- Inputs other than `clr_ov_i` and `ready_i` are ignored outside IDLE.

## Timing
- Reset value of every output: `ready_o`=1 after reset; `valid_o`, `result_o`, `ov_o` and `ov_sticky_o` are all 0. The FSM is in IDLE and the counter is 0.
- Latency: with the accepting edge at t, `valid_o` is high from cycle t+N.
  - Width=32, NumMul=1 gives N=2 for 16-bit lanes and N=4 for 8-bit lanes.
- After the DONE handshake edge, the unit is in IDLE one cycle later. Maximum throughput is one op per N+2 cycles.
- `valid_o` and `result_o` hold indefinitely while `ready_i`=0.
- `rst_ni` low at any time, including mid-CALC, immediately forces IDLE and the reset values. A partial result is discarded.

## Configuration
- `IBEX_PEXT_MAC_ROUND_EN` defined: HALVING adds 2^(E-1) to `s` before taking the high half (rounding, as in the `u` variants).
- Not defined: HALVING truncates.
- NONE and SATURATING behave identically in both builds.

## Test plan
Width=32, NumMul=1 unless noted.
- S16 SATURATING, rs1=0x7FFF0002, rs2=0x7FFF0003, rs3=0x00000001 -> `result_o`=0x7FFF0007, `ov_o`=1, `ov_sticky_o`=1; `valid_o` 2 cycles after accept.
- U8 NONE, rs1=0x02020202, rs2=0x81818181, rs3=0 -> `result_o`=0x02020202, `ov_o`=0, latency 4. Repeat with NumMul=2 -> latency 2.
- S16 HALVING, rs1=rs2=0x40008000, rs3=0 -> 0x10004000. U16 HALVING, rs1=0x00010001, rs2=0x80008000 -> 0x00010001 with the macro, 0x00000000 without.
- Backpressure: hold `ready_i`=0 for 3 cycles in DONE while driving `valid_i`=1 with new operands -> `result_o` stable, `ready_o`=0, new op not taken; it is accepted one cycle after the handshake.
- Assert `clr_ov_i` in the cycle a saturating op enters DONE -> sticky stays 1. `clr_ov_i` alone one cycle later -> 0.
- Deassert `rst_ni` in the first CALC cycle -> `valid_o`=0, `ready_o`=1, `result_o`=0. A fresh op then completes normally.
